// File: rtl/div_pkg.sv
// Shared divider definitions: state encoding, default width, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Divider request/response bundle between the ALU issue logic and seq_divider.
// Latency: n/a (wires only).
// Backpressure: none; the issuer stalls on busy. Optional SEQ_DIVIDER_REMAINDER_EN adds data_remainder.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
`ifdef SEQ_DIVIDER_REMAINDER_EN
        , input data_remainder
`endif
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
`ifdef SEQ_DIVIDER_REMAINDER_EN
        , output data_remainder
`endif
    );

endinterface

// File: rtl/cla_adder.sv
// Carry-lookahead adder: 4-bit groups with group generate/propagate lookahead between groups.
// Latency: combinational.
// Backpressure: n/a.
module cla_adder
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NB = (WIDTH + 3) / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NB:0]      bc;   // carry into each 4-bit group
    logic             c;
    logic             gg;
    logic             pp;

    assign g = a & b;
    assign p = a ^ b;

    // Sum bits ripple inside a group; group carries come from lookahead terms.
    always_comb begin
        bc    = '0;
        sum   = '0;
        c     = 1'b0;
        gg    = 1'b0;
        pp    = 1'b1;
        bc[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % 4 == 0) begin
                c  = bc[i/4];
                gg = 1'b0;
                pp = 1'b1;
            end
            sum[i] = p[i] ^ c;
            c      = g[i] | (p[i] & c);
            gg     = g[i] | (p[i] & gg);
            pp     = pp & p[i];
            if ((i % 4 == 3) || (i == WIDTH - 1)) begin
                bc[i/4 + 1] = gg | (pp & bc[i/4]);
            end
        end
    end

    assign cout = bc[NB];

endmodule

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract |B|, keep or restore.
// Latency: combinational.
// Backpressure: n/a.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] abs_b,
    output logic [WIDTH:0]   r_nxt,
    output logic [WIDTH-1:0] q_nxt
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           no_borrow;
    logic           fits;

    assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};

    // R - |B| as R + ~|B| + 1; carry out set means no borrow.
    cla_adder #(.WIDTH(WIDTH + 1)) u_sub (
        .a    (shifted),
        .b    (~{1'b0, abs_b}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // A set top bit of R is shifted out but still makes the partial remainder exceed |B|.
    assign fits  = r[WIDTH] | no_borrow;
    assign r_nxt = fits ? diff : shifted;
    assign q_nxt = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per cycle; optional SEQ_DIVIDER_REMAINDER_EN adds remainder.
// Latency: RDY WIDTH+2 cycles after start, 2 cycles for divide-by-zero/overflow.
// Backpressure: none; start is ignored while busy, issuer stalls on busy until RDY.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic        clock,
    input  logic        reset_n,
    seq_divider_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             qneg;
    logic             ovf;
    logic             exc_pend;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    logic             rneg;
    logic [WIDTH-1:0] rem_q;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .r     (r),
        .q     (q),
        .abs_b (abs_b),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    // Control FSM, operand latch, iteration registers and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            abs_a    <= '0;
            abs_b    <= '0;
            qneg     <= 1'b0;
            ovf      <= 1'b0;
            exc_pend <= 1'b0;
            r        <= '0;
            q        <= '0;
            cnt      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SEQ_DIVIDER_REMAINDER_EN
            rneg     <= 1'b0;
            rem_q    <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.ctrl_DIV) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                        abs_a  <= magnitude(bus.data_operandA);
                        abs_b  <= magnitude(bus.data_operandB);
                        qneg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                        ovf    <= (bus.data_operandA == MIN_VAL) && (&bus.data_operandB);
`ifdef SEQ_DIVIDER_REMAINDER_EN
                        rneg   <= bus.data_operandA[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    // Exceptions preload Q with the final answer and skip straight to the
                    // last ITER cycle, so they share the normal completion path.
                    state <= ITER;
                    r     <= '0;
                    if ((abs_b == '0) || ovf) begin
                        q        <= (abs_b == '0) ? '0 : MIN_VAL;
                        qneg     <= 1'b0;
                        exc_pend <= 1'b1;
                        cnt      <= CW'(WIDTH);
`ifdef SEQ_DIVIDER_REMAINDER_EN
                        rneg     <= 1'b0;
`endif
                    end else begin
                        q        <= abs_a;
                        exc_pend <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ITER: begin
                    if (cnt == CW'(WIDTH)) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                        result_q <= qneg ? -q : q;
                        exc_q    <= exc_pend;
`ifdef SEQ_DIVIDER_REMAINDER_EN
                        rem_q    <= rneg ? -r[WIDTH-1:0] : r[WIDTH-1:0];
`endif
                    end else begin
                        r   <= r_nxt;
                        q   <= q_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    assign bus.data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal answers plus random traffic against an arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_divider;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic for one operation.
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output bit exc,
                                      output logic [31:0] rem, output int lat);
        if (b == 32'd0) begin
            res = 32'd0; exc = 1'b1; rem = 32'd0; lat = 2;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000; exc = 1'b1; rem = 32'd0; lat = 2;
        end else begin
            res = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
            exc = 1'b0;
            lat = LAT;
        end
    endfunction

    // Model state, advanced at every rising edge from the inputs the bench is driving.
    int          edge_n    = 0;
    bit          pending   = 1'b0;
    int          done_edge = 0;
    logic [31:0] p_res, p_rem;
    bit          p_exc;
    logic [31:0] m_res = '0, m_rem = '0;
    bit          m_exc = 1'b0, m_rdy = 1'b0, m_busy = 1'b0;

    initial begin
        int lat;
        forever begin
            @(posedge clk);
            edge_n++;
            if (!rst_n) begin
                pending = 1'b0;
                m_res = '0; m_rem = '0; m_exc = 1'b0; m_rdy = 1'b0; m_busy = 1'b0;
            end else begin
                if (bus.ctrl_DIV && (!pending || edge_n > done_edge)) begin
                    model_div(bus.data_operandA, bus.data_operandB, p_res, p_exc, p_rem, lat);
                    pending   = 1'b1;
                    done_edge = edge_n + lat;
                end
                m_rdy = pending && (edge_n == done_edge);
                if (m_rdy) begin
                    m_res = p_res; m_exc = p_exc; m_rem = p_rem;
                end
                m_busy = pending && (edge_n < done_edge);
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("rdy",    32'(bus.data_resultRDY), 32'(m_rdy));
                check("busy",   32'(bus.busy),           32'(m_busy));
                check("result", bus.data_result,         m_res);
                check("exc",    32'(bus.data_exception), 32'(m_exc));
`ifdef SEQ_DIVIDER_REMAINDER_EN
                check("rem",    bus.data_remainder,      m_rem);
`endif
            end
        end
    end

    task automatic pulse_now(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clk);
        #1;
        bus.ctrl_DIV = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        pulse_now(a, b);
    endtask

    // Returns number of edges after the start edge at which RDY was seen (bounded).
    task automatic wait_rdy(output int k);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = bus.data_resultRDY;
        end
        k = got ? n - 1 : -1;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_exc,
                          input logic [31:0] exp_rem, input int exp_lat);
        int k;
        start_op(a, b);
        wait_rdy(k);
        check({name, "_lat"}, 32'(k), 32'(exp_lat));
        check({name, "_res"}, bus.data_result, exp_res);
        check({name, "_exc"}, 32'(bus.data_exception), 32'(exp_exc));
`ifdef SEQ_DIVIDER_REMAINDER_EN
        check({name, "_rem"}, bus.data_remainder, exp_rem);
`else
        if (exp_rem == 32'hDEAD_BEEF) $display("unexpected remainder tag");
`endif
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        int rdy_cnt;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        rst_n             = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_result", bus.data_result, 32'd0);
        check("rst_exc",    32'(bus.data_exception), 32'd0);
        check("rst_rdy",    32'(bus.data_resultRDY), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        rst_n = 1'b1;

        run_op("pos",   32'd100,        32'd7,           32'd14,          1'b0, 32'd2,          34);
        run_op("neg",   32'hFFFF_FF9C,  32'd7,           32'hFFFF_FFF2,   1'b0, 32'hFFFF_FFFE,  34);
        run_op("div0",  32'd5,          32'd0,           32'd0,           1'b1, 32'd0,          2);
        check("div0_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("div0_busy_after", 32'(bus.busy), 32'd0);
        run_op("ovf",   32'h8000_0000,  32'hFFFF_FFFF,   32'h8000_0000,   1'b1, 32'd0,          2);
        run_op("min1",  32'h8000_0000,  32'd1,           32'h8000_0000,   1'b0, 32'd0,          34);

        // Start ignored mid-iteration, then back-to-back start during DONE.
        start_op(32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #1;
        pulse_now(32'd7, 32'd7);
        wait_rdy(k);
        check("ign_res", bus.data_result, 32'd100);
        check("ign_exc", 32'(bus.data_exception), 32'd0);
        pulse_now(32'd9, 32'hFFFF_FFFD);
        wait_rdy(k);
        check("b2b_lat", 32'(k), 32'd34);
        check("b2b_res", bus.data_result, 32'hFFFF_FFFD);

        // Reset in the middle of an iteration discards the operation.
        start_op(32'd50, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_rdy",    32'(bus.data_resultRDY), 32'd0);
        check("mrst_busy",   32'(bus.busy), 32'd0);
        check("mrst_result", bus.data_result, 32'd0);
        check("mrst_exc",    32'(bus.data_exception), 32'd0);
        rdy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.data_resultRDY) rdy_cnt++;
        end
        check("mrst_no_rdy", 32'(rdy_cnt), 32'd0);
        run_op("fresh", 32'd50, 32'd5, 32'd10, 1'b0, 32'd0, 34);

        // Random traffic: sporadic starts (many land while busy), rare resets.
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.ctrl_DIV      = 1'b1;
                bus.data_operandA = rand_operand();
                bus.data_operandB = rand_operand();
            end else begin
                bus.ctrl_DIV = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.ctrl_DIV = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
